// File: rtl/dtcl_pkg.sv
// Shared types, configuration helpers and parameter legality check for the
// pipelined DTCL significand multiplier.
package dtcl_pkg;

    // Pipeline fields are sized for the widest supported significand. Narrower
    // configurations leave the upper bits at zero.
    localparam int DTCL_MAX_SIG = 32;
    localparam int DTCL_MAX_PP  = 2 * DTCL_MAX_SIG;

    typedef struct packed {
        logic                    approx;
        logic [DTCL_MAX_SIG-1:0] a;
        logic [DTCL_MAX_SIG-1:0] b;
        logic [DTCL_MAX_SIG-1:0] qa;
        logic [DTCL_MAX_SIG-1:0] qb;
    } dtcl_stage1_t;

    typedef struct packed {
        logic                   approx;
        logic [DTCL_MAX_PP-1:0] pp0;
        logic [DTCL_MAX_PP-1:0] pp1;
        logic [DTCL_MAX_PP-1:0] pp2;
        logic [DTCL_MAX_PP-1:0] pp3;
    } dtcl_stage2_t;

    function automatic int dtcl_t_bits(input int sig_w, input int e, input int a);
        return sig_w - e - a;
    endfunction

    function automatic int dtcl_chunks(input int a, input int k);
        return a / k;
    endfunction

    function automatic int dtcl_clog2(input int k);
        int r;
        r = 0;
        while ((1 << r) < k) r++;
        return r;
    endfunction

    function automatic bit dtcl_cfg_ok(input int sig_w, input int e, input int a,
                                       input int k, input int out_w);
        bit ok;
        ok = (sig_w <= DTCL_MAX_SIG) && (e >= 1) && (k >= 2) &&
             ((k & (k - 1)) == 0) && (a >= k) && ((a % k) == 0) &&
             ((e + a) <= sig_w) && (out_w >= 2 * sig_w);
        return ok;
    endfunction

endpackage

// File: rtl/dtcl_chunk_quantizer.sv
// Replaces every K-bit chunk of the approximate field by a one-hot of its
// leading one; an all-zero chunk stays zero.
module dtcl_chunk_quantizer
    import dtcl_pkg::*;
#(
    parameter int A = 12,
    parameter int K = 2
) (
    input  logic [A-1:0] i_field,
    output logic [A-1:0] o_quant
);

    localparam int NCHUNK = dtcl_chunks(A, K);
    localparam int KW     = dtcl_clog2(K);

    for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
        logic [K-1:0]  w_chunk;
        logic [KW-1:0] w_pos;
        logic          w_any;

        assign w_chunk = i_field[c*K +: K];

        // Ascending scan: the last set bit seen is the leading one.
        always_comb begin
            w_pos = '0;
            w_any = 1'b0;
            for (int j = 0; j < K; j++) begin
                if (w_chunk[j]) begin
                    w_pos = KW'(j);
                    w_any = 1'b1;
                end
            end
        end

        assign o_quant[c*K +: K] = w_any ? (K'(1) << w_pos) : '0;
    end

endmodule

// File: rtl/dtcl_sig_mul_pipe.sv
// Three-stage significand multiplier with per-operation choice between an
// exact product and the DTCL approximation; both share one bit alignment.
module dtcl_sig_mul_pipe
    import dtcl_pkg::*;
#(
    parameter int SIG_WIDTH = 24,
    parameter int E         = 4,
    parameter int A         = 12,
    parameter int K         = 2,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic                 in_approx,
    input  logic [SIG_WIDTH-1:0] in_multiplier,
    input  logic [SIG_WIDTH-1:0] in_multiplicand,
    output logic                 out_valid,
    output logic                 out_approx,
    output logic [OUT_WIDTH-1:0] out_product
);

    localparam int T    = dtcl_t_bits(SIG_WIDTH, E, A);
    localparam int LO_W = SIG_WIDTH / 2;
    localparam int HI_W = SIG_WIDTH - LO_W;
    localparam int PW   = 2 * SIG_WIDTH;

    if (!dtcl_cfg_ok(SIG_WIDTH, E, A, K, OUT_WIDTH)) begin : g_cfg_error
        $error("dtcl_sig_mul_pipe: illegal SIG_WIDTH/E/A/K/OUT_WIDTH combination");
    end

    // ---------------- stage 1: field split, rounding, quantisation ----------
    logic [A-1:0] w_fa;
    logic [A-1:0] w_fb;
    logic [A-1:0] w_qa;
    logic [A-1:0] w_qb;

    // Rounding is a plain OR of the first truncated bit into the field LSB.
    if (T > 0) begin : g_round
        assign w_fa = in_multiplier[T +: A]   | A'(in_multiplier[T-1]);
        assign w_fb = in_multiplicand[T +: A] | A'(in_multiplicand[T-1]);
    end else begin : g_no_round
        assign w_fa = in_multiplier[T +: A];
        assign w_fb = in_multiplicand[T +: A];
    end

    dtcl_chunk_quantizer #(.A(A), .K(K)) u_quant_a (
        .i_field (w_fa),
        .o_quant (w_qa)
    );

    dtcl_chunk_quantizer #(.A(A), .K(K)) u_quant_b (
        .i_field (w_fb),
        .o_quant (w_qb)
    );

    dtcl_stage1_t r_s1;
    logic         r_v1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (!stall) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1.approx <= in_approx;
                r_s1.a      <= DTCL_MAX_SIG'(in_multiplier);
                r_s1.b      <= DTCL_MAX_SIG'(in_multiplicand);
                r_s1.qa     <= DTCL_MAX_SIG'(w_qa);
                r_s1.qb     <= DTCL_MAX_SIG'(w_qb);
            end
        end
    end

    // ---------------- stage 2: partial products ------------------------------
    logic [SIG_WIDTH-1:0] w_a1;
    logic [SIG_WIDTH-1:0] w_b1;
    logic [E-1:0]         w_ea;
    logic [E-1:0]         w_eb;
    logic [A-1:0]         w_qa1;
    logic [A-1:0]         w_qb1;
    logic [HI_W-1:0]      w_a_hi;
    logic [HI_W-1:0]      w_b_hi;
    logic [LO_W-1:0]      w_a_lo;
    logic [LO_W-1:0]      w_b_lo;

    assign w_a1   = r_s1.a[SIG_WIDTH-1:0];
    assign w_b1   = r_s1.b[SIG_WIDTH-1:0];
    assign w_ea   = w_a1[SIG_WIDTH-1 -: E];
    assign w_eb   = w_b1[SIG_WIDTH-1 -: E];
    assign w_qa1  = r_s1.qa[A-1:0];
    assign w_qb1  = r_s1.qb[A-1:0];
    assign w_a_hi = w_a1[SIG_WIDTH-1 -: HI_W];
    assign w_b_hi = w_b1[SIG_WIDTH-1 -: HI_W];
    assign w_a_lo = w_a1[LO_W-1:0];
    assign w_b_lo = w_b1[LO_W-1:0];

    logic [2*E-1:0]       w_t_ee;
    logic [E+A:0]         w_t_cross;
    logic [2*A-1:0]       w_t_qq;
    logic [2*HI_W-1:0]    w_x_hh;
    logic [SIG_WIDTH-1:0] w_x_hl;
    logic [SIG_WIDTH-1:0] w_x_lh;
    logic [2*LO_W-1:0]    w_x_ll;

    // One extra bit on the cross term: it is the sum of two E x A products.
    assign w_t_ee    = (2*E)'(w_ea) * (2*E)'(w_eb);
    assign w_t_cross = (E+A+1)'(w_ea) * (E+A+1)'(w_qb1) +
                       (E+A+1)'(w_eb) * (E+A+1)'(w_qa1);
    assign w_t_qq    = (2*A)'(w_qa1) * (2*A)'(w_qb1);

    assign w_x_hh = (2*HI_W)'(w_a_hi) * (2*HI_W)'(w_b_hi);
    assign w_x_hl = SIG_WIDTH'(w_a_hi) * SIG_WIDTH'(w_b_lo);
    assign w_x_lh = SIG_WIDTH'(w_a_lo) * SIG_WIDTH'(w_b_hi);
    assign w_x_ll = (2*LO_W)'(w_a_lo) * (2*LO_W)'(w_b_lo);

    dtcl_stage2_t r_s2;
    logic         r_v2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (!stall) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2.approx <= r_s1.approx;
                if (r_s1.approx) begin
                    r_s2.pp0 <= DTCL_MAX_PP'(w_t_ee);
                    r_s2.pp1 <= DTCL_MAX_PP'(w_t_cross);
                    r_s2.pp2 <= DTCL_MAX_PP'(w_t_qq);
                    r_s2.pp3 <= '0;
                end else begin
                    r_s2.pp0 <= DTCL_MAX_PP'(w_x_hh);
                    r_s2.pp1 <= DTCL_MAX_PP'(w_x_hl);
                    r_s2.pp2 <= DTCL_MAX_PP'(w_x_lh);
                    r_s2.pp3 <= DTCL_MAX_PP'(w_x_ll);
                end
            end
        end
    end

    // ---------------- stage 3: shift and accumulate --------------------------
    logic [PW-1:0] w_p0;
    logic [PW-1:0] w_p1;
    logic [PW-1:0] w_p2;
    logic [PW-1:0] w_p3;
    logic [PW-1:0] w_sum_apx;
    logic [PW-1:0] w_sum_exact;
    logic [PW-1:0] w_sum;

    assign w_p0 = PW'(r_s2.pp0);
    assign w_p1 = PW'(r_s2.pp1);
    assign w_p2 = PW'(r_s2.pp2);
    assign w_p3 = PW'(r_s2.pp3);

    // The final 2T shift puts the approximation on the exact product's grid.
    assign w_sum_apx   = ((w_p0 << (2*A)) + (w_p1 << A) + w_p2) << (2*T);
    assign w_sum_exact = (w_p0 << (2*LO_W)) + ((w_p1 + w_p2) << LO_W) + w_p3;
    assign w_sum       = r_s2.approx ? w_sum_apx : w_sum_exact;

    logic                 r_v3;
    logic                 r_approx3;
    logic [OUT_WIDTH-1:0] r_p3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v3      <= 1'b0;
            r_approx3 <= 1'b0;
            r_p3      <= '0;
        end else if (!stall) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_approx3 <= r_s2.approx;
                r_p3      <= OUT_WIDTH'(w_sum);
            end
        end
    end

    assign out_valid   = r_v3;
    assign out_approx  = r_approx3;
    assign out_product = r_p3;

    // Upper bits of the max-width pipeline fields are only live for the widest
    // configuration.
    logic w_unused_fields;
    assign w_unused_fields = ^{r_s1, r_s2};

endmodule

// File: tb/tb_dtcl_sig_mul_pipe.sv
// Directed-vector bench for dtcl_sig_mul_pipe (default parameters): table of
// hand-computed products, stall/reset/latency sequences and a random stream.
module tb_dtcl_sig_mul_pipe;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        in_valid;
    logic        in_approx;
    logic [23:0] in_multiplier;
    logic [23:0] in_multiplicand;
    logic        out_valid;
    logic        out_approx;
    logic [63:0] out_product;

    dtcl_sig_mul_pipe dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .in_valid        (in_valid),
        .in_approx       (in_approx),
        .in_multiplier   (in_multiplier),
        .in_multiplicand (in_multiplicand),
        .out_valid       (out_valid),
        .out_approx      (out_approx),
        .out_product     (out_product)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [64:0] exp_q[$];

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        m;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] quant12(input logic [11:0] f);
        logic [11:0] q;
        logic [1:0]  ch;
        q = '0;
        for (int c = 0; c < 6; c++) begin
            ch = f[2*c +: 2];
            case (ch)
                2'b00:   q[2*c +: 2] = 2'b00;
                2'b01:   q[2*c +: 2] = 2'b01;
                default: q[2*c +: 2] = 2'b10;
            endcase
        end
        return q;
    endfunction

    function automatic logic [63:0] approx_ref(input logic [23:0] a, input logic [23:0] b);
        logic [11:0] fa;
        logic [11:0] fb;
        longint      ea, eb, qa, qb, s;
        fa    = a[19:8];
        fb    = b[19:8];
        fa[0] = fa[0] | a[7];
        fb[0] = fb[0] | b[7];
        ea = longint'(a[23:20]);
        eb = longint'(b[23:20]);
        qa = longint'(quant12(fa));
        qb = longint'(quant12(fb));
        s  = (((ea * eb) << 24) + ((ea * qb + eb * qa) << 12) + qa * qb) << 16;
        return 64'(s);
    endfunction

    function automatic logic [63:0] exact_ref(input logic [23:0] a, input logic [23:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic m,
                        input logic [63:0] p, input bit rnd);
        in_valid        = 1'b1;
        in_multiplier   = a;
        in_multiplicand = b;
        in_approx       = m;
        exp_q.push_back({m, p});
        stall = rnd && ($urandom_range(0, 7) == 0);
        @(posedge clk);
        while (stall) begin
            #1;
            stall = rnd && ($urandom_range(0, 3) == 0);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 65'(exp_q.size()), 65'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    // A result is consumed when it is valid and the pipe is not stalled.
    always @(negedge clk) begin
        logic [64:0] w_exp;
        if (reset_n && out_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %h, expected no output",
                         {out_approx, out_product});
            end else begin
                w_exp = exp_q.pop_front();
                check($sformatf("out%0d", n_out), {out_approx, out_product}, w_exp);
                n_out++;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        tbl[0]  = '{24'h800000, 24'h800000, 1'b0, 64'h0000_4000_0000_0000};
        tbl[1]  = '{24'h800000, 24'h800000, 1'b1, 64'h0000_4000_0000_0000};
        tbl[2]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 64'h0000_F570_78E4_0000};
        tbl[3]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 64'h0000_FFFF_FE00_0001};
        tbl[4]  = '{24'h000000, 24'h123456, 1'b0, 64'h0};
        tbl[5]  = '{24'h000000, 24'h123456, 1'b1, 64'h0};
        tbl[6]  = '{24'h800080, 24'h800000, 1'b1, 64'h0000_4000_8000_0000};
        tbl[7]  = '{24'h800000, 24'h800080, 1'b1, 64'h0000_4000_8000_0000};
        tbl[8]  = '{24'h800080, 24'h800000, 1'b0, 64'h0000_4000_4000_0000};
        tbl[9]  = '{24'h830000, 24'h800000, 1'b1, 64'h0000_4100_0000_0000};
        tbl[10] = '{24'h830000, 24'h800000, 1'b0, 64'h0000_4180_0000_0000};
        tbl[11] = '{24'hFFFFFF, 24'h800000, 1'b1, 64'h0000_7D55_0000_0000};
        tbl[12] = '{24'hFFFFFF, 24'h800000, 1'b0, 64'h0000_7FFF_FF80_0000};
        tbl[13] = '{24'h000001, 24'hFFFFFF, 1'b0, 64'h0000_0000_00FF_FFFF};
        tbl[14] = '{24'h000001, 24'hFFFFFF, 1'b1, 64'h0};
        tbl[15] = '{24'h000080, 24'hFFFFFF, 1'b1, 64'h0000_0000_FAAA_0000};

        reset_n         = 1'b0;
        stall           = 1'b0;
        in_valid        = 1'b0;
        in_approx       = 1'b0;
        in_multiplier   = '0;
        in_multiplicand = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid",   65'(out_valid),   65'd0);
        check("reset_out_approx",  65'(out_approx),  65'd0);
        check("reset_out_product", 65'(out_product), 65'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, streamed back-to-back (modes alternate freely)
        for (int i = 0; i < 16; i++) send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].p, 1'b0);
        drain("drain_table");

        // Stall for two cycles with three operations in flight
        send(tbl[2].a, tbl[2].b, tbl[2].m, tbl[2].p, 1'b0);
        send(tbl[3].a, tbl[3].b, tbl[3].m, tbl[3].p, 1'b0);
        send(tbl[0].a, tbl[0].b, tbl[0].m, tbl[0].p, 1'b0);
        in_valid        = 1'b1;
        in_multiplier   = tbl[6].a;
        in_multiplicand = tbl[6].b;
        in_approx       = tbl[6].m;
        exp_q.push_back({tbl[6].m, tbl[6].p});
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_hold_valid%0d", c),   65'(out_valid),   65'd1);
            check($sformatf("stall_hold_product%0d", c), 65'(out_product), 65'(tbl[2].p));
            check($sformatf("stall_hold_approx%0d", c),  65'(out_approx),  65'd1);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(tbl[8].a, tbl[8].b, tbl[8].m, tbl[8].p, 1'b0);
        drain("drain_stall");

        // Asynchronous reset with three operations in flight
        send(tbl[11].a, tbl[11].b, tbl[11].m, tbl[11].p, 1'b0);
        send(tbl[12].a, tbl[12].b, tbl[12].m, tbl[12].p, 1'b0);
        send(tbl[15].a, tbl[15].b, tbl[15].m, tbl[15].p, 1'b0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid",   65'(out_valid),   65'd0);
        check("midreset_out_approx",  65'(out_approx),  65'd0);
        check("midreset_out_product", 65'(out_product), 65'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First operation after release: output exactly three edges later
        send(tbl[2].a, tbl[2].b, tbl[2].m, tbl[2].p, 1'b0);
        check("latency_edge1", 65'(out_valid), 65'd0);
        @(posedge clk);
        #1;
        check("latency_edge2", 65'(out_valid), 65'd0);
        @(posedge clk);
        #1;
        check("latency_edge3", 65'(out_valid), 65'd1);
        drain("drain_reset");

        // Random stream with random stalls; approximate pairs sent in both orders
        for (int i = 0; i < 2000; i++) begin
            logic [23:0] ra;
            logic [23:0] rb;
            logic        rm;
            logic [63:0] rp;
            ra = 24'($urandom());
            rb = 24'($urandom());
            rm = 1'($urandom_range(0, 1));
            rp = rm ? approx_ref(ra, rb) : exact_ref(ra, rb);
            send(ra, rb, rm, rp, 1'b1);
            if (rm) send(rb, ra, rm, rp, 1'b1);
        end
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
